// File: rtl/alu_defs.sv
// Shared ALU opcode constants, instruction word layout and sequencer FSM encoding.
package alu_defs;

  localparam int unsigned OPC_W     = 4;
  localparam int unsigned OPERAND_W = 16;
  localparam int unsigned INSN_REP_W = 6;
  localparam int unsigned OPC_LSB   = 16;
  localparam int unsigned REP_LSB   = 20;
  localparam int unsigned INSN_W    = 26;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_WR_PRI = 4'h0;
  localparam opcode_t OP_WR_SEC = 4'h1;
  localparam opcode_t OP_ADD    = 4'h2;
  localparam opcode_t OP_SUB    = 4'h3;
  localparam opcode_t OP_AND    = 4'h4;
  localparam opcode_t OP_OR     = 4'h5;
  localparam opcode_t OP_XOR    = 4'h6;
  localparam opcode_t OP_SHL    = 4'h7;
  localparam opcode_t OP_SHR    = 4'h8;
  localparam opcode_t OP_ROL    = 4'h9;
  localparam opcode_t OP_ROR    = 4'hA;
  localparam opcode_t OP_MUL    = 4'hB;
  localparam opcode_t OP_NOT    = 4'hC;
  localparam opcode_t OP_MOV    = 4'hD;
  localparam opcode_t OP_CMP    = 4'hE;
  localparam opcode_t OP_HALT   = 4'hF;

  // Field order matches {rep[25:20], opcode[19:16], operand[15:0]}.
  typedef struct packed {
    logic [INSN_REP_W-1:0] rep;
    opcode_t               opc;
    logic [OPERAND_W-1:0]  operand;
  } insn_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Program-load and opcode-issue bus between host, sequencer and ALU.
// SEQ_SINGLE_STEP_EN adds step_i / step_mode_i.
interface alu_op_sequencer_if #(
  parameter int unsigned AW = 5
);
  import alu_defs::*;

  logic                 prog_we_i;
  logic [AW-1:0]        prog_addr_i;
  insn_t                prog_data_i;
  logic                 start_i;
  logic                 busy_o;
  logic                 done_o;
  opcode_t              opcode_o;
  logic [OPERAND_W-1:0] operand_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [AW-1:0]        pc_o;
`ifdef SEQ_SINGLE_STEP_EN
  logic                 step_i;
  logic                 step_mode_i;

  modport master (
    output prog_we_i, prog_addr_i, prog_data_i, start_i, ready_i, step_i, step_mode_i,
    input  busy_o, done_o, opcode_o, operand_o, valid_o, pc_o
  );

  modport slave (
    input  prog_we_i, prog_addr_i, prog_data_i, start_i, ready_i, step_i, step_mode_i,
    output busy_o, done_o, opcode_o, operand_o, valid_o, pc_o
  );
`else
  modport master (
    output prog_we_i, prog_addr_i, prog_data_i, start_i, ready_i,
    input  busy_o, done_o, opcode_o, operand_o, valid_o, pc_o
  );

  modport slave (
    input  prog_we_i, prog_addr_i, prog_data_i, start_i, ready_i,
    output busy_o, done_o, opcode_o, operand_o, valid_o, pc_o
  );
`endif

endinterface

// File: rtl/seq_program_ram.sv
// Microprogram store: DEPTH x INSN_W simple dual-port RAM, 1-cycle synchronous read.
module seq_program_ram
  import alu_defs::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  insn_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output insn_t         rdata_o
);

  insn_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read data holds while re_i is low so the issued word stays visible.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Streams {opcode, operand} words from program RAM to the ALU with repeat looping and HALT detection.
// SEQ_SINGLE_STEP_EN: FETCH->ISSUE gated by step_i while step_mode_i is set.
module alu_op_sequencer
  import alu_defs::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned REP_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  alu_op_sequencer_if.slave bus
);

  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  seq_state_t           state, state_nxt;
  logic [AW-1:0]        pc, pc_nxt;
  logic [REP_W-1:0]     rep_cnt, rep_cnt_nxt;
  insn_t                ram_q;
  logic                 ram_re;
  logic [AW-1:0]        ram_raddr;
  logic                 ram_we;
  logic                 xfer;
  logic                 halt_word;
  logic                 fetch_go;
  logic                 busy_nxt, done_nxt, valid_nxt;
  opcode_t              opcode_nxt;
  logic [OPERAND_W-1:0] operand_nxt;

  assign ram_we    = bus.prog_we_i && (state == ST_IDLE);
  assign xfer      = bus.valid_o && bus.ready_i;
  assign halt_word = (ram_q.opc == OP_HALT);
  assign bus.pc_o  = pc;

`ifdef SEQ_SINGLE_STEP_EN
  assign fetch_go = !bus.step_mode_i || bus.step_i;
`else
  assign fetch_go = 1'b1;
`endif

  seq_program_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (bus.prog_addr_i),
    .wdata_i (bus.prog_data_i),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_q)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; the word read on FETCH entry stays in ram_q through ISSUE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.start_i) state_nxt = ST_FETCH;
      ST_FETCH: if (fetch_go) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (halt_word) begin
          state_nxt = ST_DONE;
        end else if (xfer && (rep_cnt == '0)) begin
          state_nxt = (pc == LAST_PC) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next values; the RAM is read at the edge entering FETCH.
  always_comb begin
    pc_nxt      = pc;
    rep_cnt_nxt = rep_cnt;
    valid_nxt   = bus.valid_o;
    opcode_nxt  = bus.opcode_o;
    operand_nxt = bus.operand_o;
    ram_re      = 1'b0;
    ram_raddr   = pc + AW'(1);
    busy_nxt    = (state_nxt == ST_FETCH) || (state_nxt == ST_ISSUE);
    done_nxt    = (state_nxt == ST_DONE);
    unique case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          pc_nxt      = '0;
          rep_cnt_nxt = '0;
          ram_re      = 1'b1;
          ram_raddr   = '0;
        end
      end
      ST_FETCH: begin
        if (fetch_go) begin
          valid_nxt   = !halt_word;
          rep_cnt_nxt = REP_W'(ram_q.rep);
          if (!halt_word) begin
            opcode_nxt  = ram_q.opc;
            operand_nxt = ram_q.operand;
          end
        end
      end
      ST_ISSUE: begin
        if (xfer) begin
          if (rep_cnt != '0) begin
            rep_cnt_nxt = rep_cnt - REP_W'(1);
          end else begin
            valid_nxt = 1'b0;
            // Last word is an implicit HALT: pc never wraps.
            if (pc != LAST_PC) begin
              pc_nxt = pc + AW'(1);
              ram_re = 1'b1;
            end
          end
        end
      end
      default: begin
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc            <= '0;
      rep_cnt       <= '0;
      bus.busy_o    <= 1'b0;
      bus.done_o    <= 1'b0;
      bus.valid_o   <= 1'b0;
      bus.opcode_o  <= '0;
      bus.operand_o <= '0;
    end else begin
      pc            <= pc_nxt;
      rep_cnt       <= rep_cnt_nxt;
      bus.busy_o    <= busy_nxt;
      bus.done_o    <= done_nxt;
      bus.valid_o   <= valid_nxt;
      bus.opcode_o  <= opcode_nxt;
      bus.operand_o <= operand_nxt;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a 32-word instance plus a 4-word instance for the no-wrap case.
module tb_alu_op_sequencer;
  import alu_defs::*;

  logic clk;
  logic rst_n;

  alu_op_sequencer_if #(.AW(5)) bus_a();
  alu_op_sequencer_if #(.AW(2)) bus_b();

  alu_op_sequencer #(.DEPTH(32), .AW(5), .REP_W(6)) dut_a (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_a)
  );

  alu_op_sequencer #(.DEPTH(4), .AW(2), .REP_W(6)) dut_b (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transfer log of the last run on dut_a, cycle index = edges since start acceptance.
  int          xf_n;
  logic [3:0]  xf_opc [64];
  logic [15:0] xf_opd [64];
  int          xf_cyc [64];
  int          first_valid;
  int          done_cyc;
  int          done_cnt;
  int          hold_err;
  int          busy0;
  int          post_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic insn_t mk(input int rep, input opcode_t opc, input logic [15:0] opd);
    insn_t w;
    w.rep     = 6'(rep);
    w.opc     = opc;
    w.operand = opd;
    return w;
  endfunction

  task automatic write_a(input int addr, input insn_t w);
    bus_a.prog_we_i   = 1'b1;
    bus_a.prog_addr_i = 5'(addr);
    bus_a.prog_data_i = w;
    tick();
    bus_a.prog_we_i   = 1'b0;
  endtask

  task automatic load_prog1();
    write_a(0, mk(0, OP_WR_PRI, 16'h1234));
    write_a(1, mk(0, OP_SHL, 16'h0000));
    write_a(2, mk(0, OP_HALT, 16'h0000));
  endtask

  // Start dut_a and log until two cycles past done_o; ready_i low for k in [stall_lo, stall_hi];
  // at k == poke_k, start_i and a program write to address 1 are presented for one edge.
  task automatic run_a(input int stall_lo, input int stall_hi, input int poke_k);
    logic        pv;
    logic        prdy;
    logic [3:0]  po;
    logic [15:0] pd;
    xf_n = 0; first_valid = -1; done_cyc = -1; done_cnt = 0; hold_err = 0;
    busy0 = -1; post_busy = -1;
    pv = 1'b0; prdy = 1'b1; po = '0; pd = '0;
    bus_a.ready_i = 1'b1;
    bus_a.start_i = 1'b1;
    tick();
    bus_a.start_i = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (k == 0) busy0 = int'(bus_a.busy_o);
      if (pv && !prdy &&
          (bus_a.valid_o !== 1'b1 || bus_a.opcode_o !== po || bus_a.operand_o !== pd))
        hold_err++;
      if (bus_a.valid_o && first_valid < 0) first_valid = k;
      if (bus_a.done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc >= 0 && k == done_cyc + 1) post_busy = int'(bus_a.busy_o);
      prdy = !(k >= stall_lo && k <= stall_hi);
      bus_a.ready_i = prdy;
      if (bus_a.valid_o && prdy && xf_n < 64) begin
        xf_opc[xf_n] = bus_a.opcode_o;
        xf_opd[xf_n] = bus_a.operand_o;
        xf_cyc[xf_n] = k;
        xf_n++;
      end
      pv = bus_a.valid_o; po = bus_a.opcode_o; pd = bus_a.operand_o;
      if (k == poke_k) begin
        bus_a.start_i     = 1'b1;
        bus_a.prog_we_i   = 1'b1;
        bus_a.prog_addr_i = 5'd1;
        bus_a.prog_data_i = mk(0, OP_CMP, 16'hFFFF);
      end else begin
        bus_a.start_i   = 1'b0;
        bus_a.prog_we_i = 1'b0;
      end
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
      tick();
    end
    bus_a.ready_i   = 1'b1;
    bus_a.start_i   = 1'b0;
    bus_a.prog_we_i = 1'b0;
  endtask

  initial begin
    int nb;
    int dcb;
    int pcb;
    int pcb_late;
    int busyb;
    int dpulse;

    rst_n = 1'b0;
    bus_a.prog_we_i = 1'b0; bus_a.prog_addr_i = '0; bus_a.prog_data_i = '0;
    bus_a.start_i = 1'b0; bus_a.ready_i = 1'b1;
    bus_b.prog_we_i = 1'b0; bus_b.prog_addr_i = '0; bus_b.prog_data_i = '0;
    bus_b.start_i = 1'b0; bus_b.ready_i = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    bus_a.step_i = 1'b0; bus_a.step_mode_i = 1'b0;
    bus_b.step_i = 1'b0; bus_b.step_mode_i = 1'b0;
`endif
    tick();
    tick();

    // Reset state
    check("rst_valid",   32'(bus_a.valid_o),   32'd0);
    check("rst_busy",    32'(bus_a.busy_o),    32'd0);
    check("rst_done",    32'(bus_a.done_o),    32'd0);
    check("rst_pc",      32'(bus_a.pc_o),      32'd0);
    check("rst_opcode",  32'(bus_a.opcode_o),  32'd0);
    check("rst_operand", 32'(bus_a.operand_o), 32'd0);
    check("rst_b_pc",    32'(bus_b.pc_o),      32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: two plain words then HALT
    load_prog1();
    run_a(100, -1, -1);
    check("t1_busy_start", 32'(busy0),        32'd1);
    check("t1_xf_n",       32'(xf_n),         32'd2);
    check("t1_opc0",       32'(xf_opc[0]),    32'h0);
    check("t1_opd0",       32'(xf_opd[0]),    32'h1234);
    check("t1_opc1",       32'(xf_opc[1]),    32'h7);
    check("t1_opd1",       32'(xf_opd[1]),    32'h0000);
    check("t1_first_valid", 32'(first_valid), 32'd1);
    check("t1_xf_cyc1",    32'(xf_cyc[1]),    32'd3);
    check("t1_done_cyc",   32'(done_cyc),     32'd6);
    check("t1_done_cnt",   32'(done_cnt),     32'd1);
    check("t1_busy_after", 32'(post_busy),    32'd0);

    // Test 2: one word repeated 4 times
    write_a(0, mk(3, OP_SUB, 16'h0000));
    write_a(1, mk(0, OP_HALT, 16'h0000));
    run_a(100, -1, -1);
    check("t2_xf_n", 32'(xf_n), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_opc%0d", i), 32'(xf_opc[i]), 32'h3);
    check("t2_span",     32'(xf_cyc[3] - xf_cyc[0]), 32'd3);
    check("t2_done_cyc", 32'(done_cyc),              32'd7);

    // Test 3: ready_i low for 5 cycles while word 0 is offered
    load_prog1();
    run_a(1, 5, -1);
    check("t3_hold_err", 32'(hold_err),  32'd0);
    check("t3_xf_n",     32'(xf_n),      32'd2);
    check("t3_opc0",     32'(xf_opc[0]), 32'h0);
    check("t3_opd0",     32'(xf_opd[0]), 32'h1234);
    check("t3_opc1",     32'(xf_opc[1]), 32'h7);
    check("t3_xf_cyc0",  32'(xf_cyc[0]), 32'd6);
    check("t3_done_cyc", 32'(done_cyc),  32'd11);

    // Test 4: start_i and a program write while busy are ignored
    run_a(100, -1, 2);
    check("t4_xf_n",     32'(xf_n),      32'd2);
    check("t4_opc1",     32'(xf_opc[1]), 32'h7);
    check("t4_done_cyc", 32'(done_cyc),  32'd6);
    check("t4_done_cnt", 32'(done_cnt),  32'd1);
    run_a(100, -1, -1);
    check("t4_rb_opc1", 32'(xf_opc[1]), 32'h7);
    check("t4_rb_opd1", 32'(xf_opd[1]), 32'h0000);
    check("t4_rb_xf_n", 32'(xf_n),      32'd2);

    // Test 5: 4-deep program with no HALT stops at the last word
    for (int i = 0; i < 4; i++) begin
      bus_b.prog_we_i   = 1'b1;
      bus_b.prog_addr_i = 2'(i);
      bus_b.prog_data_i = mk(0, OP_ADD, 16'(i));
      tick();
    end
    bus_b.prog_we_i = 1'b0;
    bus_b.start_i   = 1'b1;
    tick();
    bus_b.start_i = 1'b0;
    nb = 0; dcb = -1; pcb = -1; pcb_late = -1; busyb = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus_b.valid_o && bus_b.ready_i) begin
        nb++;
        if (bus_b.opcode_o !== OP_ADD) nb += 100;
      end
      if (bus_b.done_o && dcb < 0) begin
        dcb = k;
        pcb = int'(bus_b.pc_o);
      end
      if (dcb >= 0 && k == dcb + 1) busyb = int'(bus_b.busy_o);
      if (dcb >= 0 && k == dcb + 3) begin
        pcb_late = int'(bus_b.pc_o);
        break;
      end
      tick();
    end
    check("t5_issues",    32'(nb),       32'd4);
    check("t5_done_cyc",  32'(dcb),      32'd8);
    check("t5_pc_done",   32'(pcb),      32'd3);
    check("t5_pc_late",   32'(pcb_late), 32'd3);
    check("t5_busy_after", 32'(busyb),   32'd0);

    // Test 6: reset in the middle of a repeat burst
    write_a(0, mk(5, OP_ROL, 16'hABCD));
    write_a(1, mk(0, OP_WR_SEC, 16'h0001));
    write_a(2, mk(0, OP_HALT, 16'h0000));
    bus_a.ready_i = 1'b1;
    bus_a.start_i = 1'b1;
    tick();
    bus_a.start_i = 1'b0;
    tick();
    tick();
    check("t6_burst_valid", 32'(bus_a.valid_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus_a.valid_o), 32'd0);
    check("t6_rst_busy",  32'(bus_a.busy_o),  32'd0);
    check("t6_rst_pc",    32'(bus_a.pc_o),    32'd0);
    tick();
    rst_n = 1'b1;
    dpulse = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus_a.done_o) dpulse++;
    end
    check("t6_no_done", 32'(dpulse),        32'd0);
    check("t6_idle",    32'(bus_a.busy_o),  32'd0);
    run_a(100, -1, -1);
    check("t6_xf_n",     32'(xf_n),      32'd7);
    check("t6_opc0",     32'(xf_opc[0]), 32'h9);
    check("t6_opd0",     32'(xf_opd[0]), 32'hABCD);
    check("t6_opc6",     32'(xf_opc[6]), 32'h1);
    check("t6_opd6",     32'(xf_opd[6]), 32'h0001);
    check("t6_done_cyc", 32'(done_cyc),  32'd11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
